// File: rtl/io_bridge.sv
// -----------------------------------------------------------------------------
// io_bridge
//
// Splits CPU accesses between a RAM path and a multi-channel IO path. The top
// address bit selects IO. RAM accesses are decoded combinationally and passed
// straight through. IO accesses are latched and presented to one IO channel
// until the channel acknowledges. The CPU is stalled while this happens, and
// the IO read data is returned in a one-cycle DONE state.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cpu_valid/addr/wdata/rw
//                         CPU request; rw=1 is a write
//   cpu_rdata             IO result; held until the next IO completion
//   cpu_stall             CPU must hold its request
//   cpu_err               one-cycle pulse in DONE on a bad channel or timeout
//   ram_en, ram_rw        combinational RAM strobe and direction
//   io_req, io_sel        IO request and one-hot channel select
//   io_port, io_wdata, io_rw
//                         latched port number, write data and direction
//   io_ack, io_rdata      IO acknowledge and read data
//
// Build option
//   IO_BRIDGE_TIMEOUT_EN  when defined, REQ is abandoned after TIMEOUT_CYC
//                         cycles without io_ack (error, all-ones data).
//                         When undefined, REQ waits for io_ack indefinitely.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no IO in flight; an IO request is latched here
// REQ   | io_req high towards the selected channel, waiting for io_ack
// DONE  | one cycle; cpu_rdata/cpu_err valid, stall released
// -----------------------------------------------------------------------------
module io_bridge #(
    parameter int ADDR_W      = 48,
    parameter int DATA_W      = 64,
    parameter int IO_W        = 16,
    parameter int PORT_W      = 16,
    parameter int N_PORTS     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rw,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic              ram_en,
    output logic              ram_rw,
    output logic              io_req,
    output logic [N_PORTS-1:0] io_sel,
    output logic [PORT_W-1:0] io_port,
    output logic [IO_W-1:0]   io_wdata,
    output logic              io_rw,
    input  logic              io_ack,
    input  logic [IO_W-1:0]   io_rdata
);

    // A single-channel build still keeps a one-bit index, tied to zero.
    localparam int CH_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [CH_W:0] N_LIM = N_PORTS[CH_W:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              io_access;
    logic [CH_W-1:0]   addr_ch;
    logic              ch_bad;
    logic              io_start;
    logic              timeout_hit;

    logic [CH_W-1:0]   ch_q;
    logic [PORT_W-1:0] port_q;
    logic [IO_W-1:0]   wdata_q;
    logic              rw_q;

    // Only a few address/data bits feed the IO path.
    logic unused_in;
    assign unused_in = ^{cpu_addr, cpu_wdata};

    assign io_access = cpu_valid & cpu_addr[ADDR_W-1];

    generate
        if (N_PORTS > 1) begin : g_ch
            assign addr_ch = cpu_addr[PORT_W +: CH_W];
        end else begin : g_ch_single
            assign addr_ch = '0;
        end
    endgenerate

    // Index field can encode more channels than exist when N_PORTS is not a
    // power of two.
    assign ch_bad   = ({1'b0, addr_ch} >= N_LIM);
    assign io_start = (state == IDLE) & io_access;

`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counter holds the number of REQ cycles already completed, so the limit
    // is hit during REQ cycle number TIMEOUT_CYC.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (io_start) begin
            tmo_cnt <= '0;
        end else if (state == REQ) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == REQ) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (io_access) begin
                    state_nxt = ch_bad ? DONE : REQ;
                end
            end
            REQ: begin
                if (io_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, result register and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q      <= '0;
            port_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_err <= 1'b0;
            if (io_start) begin
                ch_q    <= addr_ch;
                port_q  <= cpu_addr[PORT_W-1:0];
                wdata_q <= cpu_wdata[IO_W-1:0];
                rw_q    <= cpu_rw;
                if (ch_bad) begin
                    cpu_err   <= 1'b1;
                    cpu_rdata <= '1;
                end
            end
            if (state == REQ) begin
                // An acknowledge in the timeout cycle still completes normally.
                if (io_ack) begin
                    cpu_rdata <= DATA_W'(io_rdata);
                end else if (timeout_hit) begin
                    cpu_err   <= 1'b1;
                    cpu_rdata <= '1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        ram_en    = cpu_valid & ~cpu_addr[ADDR_W-1];
        ram_rw    = cpu_valid & ~cpu_addr[ADDR_W-1] & cpu_rw;
        cpu_stall = io_start | (state == REQ);
        io_req    = (state == REQ);
        io_port   = port_q;
        io_wdata  = wdata_q;
        io_rw     = rw_q;
        io_sel    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if ((state == REQ) && (ch_q == CH_W'(i))) begin
                io_sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid;
    logic [47:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_rw;
    logic        io_ack;
    logic [15:0] io_rdata;
    bit          tgt;   // 0: default instance, 1: 3-channel instance

    always #5 clk = ~clk;

    logic        a_valid, b_valid;
    assign a_valid = cpu_valid & ~tgt;
    assign b_valid = cpu_valid &  tgt;

    logic [63:0] a_rdata, b_rdata;
    logic        a_stall, b_stall, a_err, b_err;
    logic        a_ram_en, b_ram_en, a_ram_rw, b_ram_rw;
    logic        a_req, b_req, a_rw, b_rw;
    logic [3:0]  a_sel;
    logic [2:0]  b_sel;
    logic [15:0] a_port, b_port, a_wdata, b_wdata;

    io_bridge u_dut_a (
        .clk(clk), .reset(reset), .cpu_valid(a_valid), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw), .cpu_rdata(a_rdata),
        .cpu_stall(a_stall), .cpu_err(a_err), .ram_en(a_ram_en), .ram_rw(a_ram_rw),
        .io_req(a_req), .io_sel(a_sel), .io_port(a_port), .io_wdata(a_wdata),
        .io_rw(a_rw), .io_ack(io_ack), .io_rdata(io_rdata)
    );

    io_bridge #(.N_PORTS(3), .TIMEOUT_CYC(8)) u_dut_b (
        .clk(clk), .reset(reset), .cpu_valid(b_valid), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw), .cpu_rdata(b_rdata),
        .cpu_stall(b_stall), .cpu_err(b_err), .ram_en(b_ram_en), .ram_rw(b_ram_rw),
        .io_req(b_req), .io_sel(b_sel), .io_port(b_port), .io_wdata(b_wdata),
        .io_rw(b_rw), .io_ack(io_ack), .io_rdata(io_rdata)
    );

    logic [63:0] o_rdata;
    logic        o_stall, o_err, o_ram_en, o_ram_rw, o_req, o_rw;
    logic [3:0]  o_sel;
    logic [15:0] o_port, o_wdata;
    assign o_rdata  = tgt ? b_rdata  : a_rdata;
    assign o_stall  = tgt ? b_stall  : a_stall;
    assign o_err    = tgt ? b_err    : a_err;
    assign o_ram_en = tgt ? b_ram_en : a_ram_en;
    assign o_ram_rw = tgt ? b_ram_rw : a_ram_rw;
    assign o_req    = tgt ? b_req    : a_req;
    assign o_rw     = tgt ? b_rw     : a_rw;
    assign o_sel    = tgt ? {1'b0, b_sel} : a_sel;
    assign o_port   = tgt ? b_port   : a_port;
    assign o_wdata  = tgt ? b_wdata  : a_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          tgt;
        logic [47:0] addr;
        logic [63:0] wdata;
        bit          rw;
        int          ack_lat;    // REQ cycle carrying io_ack; 0 = never
        logic [15:0] rdata;
        logic [3:0]  exp_sel;
        logic [15:0] exp_port;
        logic [15:0] exp_wdata;
        bit          exp_err;
        logic [63:0] exp_rdata;
        int          exp_stall;
        int          exp_req;
    } io_vec_t;

    typedef struct {
        bit          valid;
        logic [47:0] addr;
        bit          rw;
        bit          exp_ram_en;
        bit          exp_ram_rw;
    } ram_vec_t;

    io_vec_t  io_tab [8];
    ram_vec_t ram_tab[6];
    int n_io  = 0;
    int n_ram = 0;

    task automatic run_io(input io_vec_t v);
        int  stall_n = 0;
        int  req_n   = 0;
        bit  done    = 1'b0;
        @(posedge clk); #1;
        tgt       = v.tgt;
        cpu_valid = 1'b1;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_rw    = v.rw;
        io_rdata  = v.rdata;
        io_ack    = (v.ack_lat == 1);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) chk("io_ram_en_low", {63'd0, o_ram_en}, 64'd0);
            if (o_stall) stall_n++;
            if (o_req) begin
                req_n++;
                chk("io_sel",   {60'd0, o_sel}, {60'd0, v.exp_sel});
                chk("io_port",  {48'd0, o_port}, {48'd0, v.exp_port});
                chk("io_wdata", {48'd0, o_wdata}, {48'd0, v.exp_wdata});
                chk("io_rw",    {63'd0, o_rw}, {63'd0, v.rw});
            end else begin
                chk("io_sel_idle", {60'd0, o_sel}, 64'd0);
            end
            if (!o_stall) begin
                done = 1'b1;
                chk("done_err",   {63'd0, o_err}, {63'd0, v.exp_err});
                chk("done_rdata", o_rdata, v.exp_rdata);
                chk("stall_cycles", 64'(stall_n), 64'(v.exp_stall));
                chk("req_cycles",   64'(req_n),   64'(v.exp_req));
                break;
            end
            @(posedge clk); #1;
            io_ack = (v.ack_lat != 0) && (req_n + 1 == v.ack_lat);
        end
        if (!done) chk("io_completion_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        io_ack    = 1'b0;
        @(negedge clk);
        chk("err_pulse_end", {63'd0, o_err}, 64'd0);
        chk("idle_no_stall", {63'd0, o_stall}, 64'd0);
        chk("rdata_hold",    o_rdata, v.exp_rdata);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_rw    = 1'b0;
        io_ack    = 1'b0;
        io_rdata  = '0;
        tgt       = 1'b0;

        //                 tgt  addr                 wdata                   rw ack rdata     sel      port      wdata    err exp_rdata                stall req
        io_tab[n_io++] = '{1'b0, 48'h8000_0002_0034, 64'h0000_0000_0000_BEEF, 1'b1, 1, 16'h5A5A, 4'b0100, 16'h0034, 16'hBEEF, 1'b0, 64'h0000_0000_0000_5A5A, 2, 1};
        io_tab[n_io++] = '{1'b0, 48'h8000_0001_0007, 64'h0,                   1'b0, 5, 16'h1234, 4'b0010, 16'h0007, 16'h0000, 1'b0, 64'h0000_0000_0000_1234, 6, 5};
        io_tab[n_io++] = '{1'b0, 48'h8000_0003_FFFF, 64'hFFFF_0000_0000_A5C3, 1'b1, 2, 16'h8001, 4'b1000, 16'hFFFF, 16'hA5C3, 1'b0, 64'h0000_0000_0000_8001, 3, 2};
        io_tab[n_io++] = '{1'b0, 48'h8000_0000_0100, 64'h0,                   1'b0, 3, 16'hFFFF, 4'b0001, 16'h0100, 16'h0000, 1'b0, 64'h0000_0000_0000_FFFF, 4, 3};
        io_tab[n_io++] = '{1'b1, 48'h8000_0003_0010, 64'h0,                   1'b0, 1, 16'h4321, 4'b0000, 16'h0000, 16'h0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
        io_tab[n_io++] = '{1'b1, 48'h8000_0002_0022, 64'h0,                   1'b0, 1, 16'h00AA, 4'b0100, 16'h0022, 16'h0000, 1'b0, 64'h0000_0000_0000_00AA, 2, 1};
`ifdef IO_BRIDGE_TIMEOUT_EN
        io_tab[n_io++] = '{1'b1, 48'h8000_0001_0005, 64'h0,                   1'b0, 0, 16'h7777, 4'b0010, 16'h0005, 16'h0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 9, 8};
        io_tab[n_io++] = '{1'b1, 48'h8000_0001_0005, 64'h0,                   1'b0, 8, 16'h7777, 4'b0010, 16'h0005, 16'h0000, 1'b0, 64'h0000_0000_0000_7777, 9, 8};
`else
        io_tab[n_io++] = '{1'b1, 48'h8000_0001_0005, 64'h0,                   1'b0, 20, 16'h7777, 4'b0010, 16'h0005, 16'h0000, 1'b0, 64'h0000_0000_0000_7777, 21, 20};
`endif

        //                  valid addr                 rw    ram_en ram_rw
        ram_tab[n_ram++] = '{1'b1, 48'h0000_0000_0040, 1'b0, 1'b1, 1'b0};
        ram_tab[n_ram++] = '{1'b1, 48'h0000_0000_0040, 1'b1, 1'b1, 1'b1};
        ram_tab[n_ram++] = '{1'b0, 48'h0000_0000_0040, 1'b1, 1'b0, 1'b0};
        ram_tab[n_ram++] = '{1'b1, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1};
        ram_tab[n_ram++] = '{1'b0, 48'h8000_0000_0000, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rdata_a", a_rdata, 64'd0);
        chk("rst_rdata_b", b_rdata, 64'd0);
        chk("rst_err",     {63'd0, a_err | b_err}, 64'd0);
        chk("rst_stall",   {63'd0, a_stall}, 64'd0);
        chk("rst_io_req",  {63'd0, a_req | b_req}, 64'd0);
        chk("rst_io_sel",  {61'd0, a_sel[3:1] | b_sel}, 64'd0);
        chk("rst_io_port", {48'd0, a_port}, 64'd0);

        // io_ack while idle is ignored
        @(posedge clk); #1 io_ack = 1'b1; io_rdata = 16'hDEAD;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ack_req",   {63'd0, a_req}, 64'd0);
            chk("idle_ack_rdata", a_rdata, 64'd0);
        end
        @(posedge clk); #1 io_ack = 1'b0;

        for (int i = 0; i < n_io; i++) run_io(io_tab[i]);

        // RAM path; IO result from the last default-instance transfer must hold
        tgt = 1'b0;
        for (int i = 0; i < n_ram; i++) begin
            @(posedge clk); #1;
            cpu_valid = ram_tab[i].valid;
            cpu_addr  = ram_tab[i].addr;
            cpu_rw    = ram_tab[i].rw;
            @(negedge clk);
            chk("ram_en",    {63'd0, a_ram_en}, {63'd0, ram_tab[i].exp_ram_en});
            chk("ram_rw",    {63'd0, a_ram_rw}, {63'd0, ram_tab[i].exp_ram_rw});
            chk("ram_stall", {63'd0, a_stall}, 64'd0);
            chk("ram_ioreq", {63'd0, a_req}, 64'd0);
            chk("ram_rdata_hold", a_rdata, 64'h0000_0000_0000_FFFF);
        end
        @(posedge clk); #1 cpu_valid = 1'b0;

        // Reset during the third REQ cycle, then a late io_ack
        tgt = 1'b0;
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_addr = 48'h8000_0001_0055; cpu_rw = 1'b0;
        io_ack = 1'b0; io_rdata = 16'h4444;
        @(negedge clk);
        chk("mrst_idle_stall", {63'd0, a_stall}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mrst_req1", {63'd0, a_req}, 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1; cpu_valid = 1'b0;
        @(negedge clk);
        chk("mrst_req3", {63'd0, a_req}, 64'd1);
        @(posedge clk); #1 reset = 1'b0; io_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_io_req", {63'd0, a_req}, 64'd0);
            chk("mrst_stall",  {63'd0, a_stall}, 64'd0);
            chk("mrst_err",    {63'd0, a_err}, 64'd0);
            chk("mrst_rdata",  a_rdata, 64'd0);
            chk("mrst_io_sel", {60'd0, a_sel}, 64'd0);
        end
        @(posedge clk); #1 io_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
